// File: rtl/icache_refill.sv
// icache_refill: instruction-cache miss handler. Issues one line-aligned
// refill request, captures the returned 256-bit line, writes it into the
// LRU-selected victim way and returns the missed word to fetch.
// Optional feature macro: ICACHE_REFILL_BYPASS_EN (respond in the FILL cycle
// instead of a separate DONE cycle).
module icache_refill #(
  parameter int INDEX_W = 7,
  parameter int TAG_W   = 20
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               miss_i,
  input  logic [31:0]        miss_addr_i,
  input  logic               hit_i,
  input  logic               hit_way_i,
  input  logic [INDEX_W-1:0] hit_index_i,
  input  logic               flush_i,
  output logic               icache_axi_req_o,
  output logic [31:0]        icache_axi_addr_o,
  input  logic               icache_axi_rend_i,
  input  logic [255:0]       icache_axi_data_i,
  output logic [1:0]         way_we_o,
  output logic [INDEX_W-1:0] wr_index_o,
  output logic [TAG_W-1:0]   wr_tag_o,
  output logic [255:0]       wr_line_o,
  output logic               resp_valid_o,
  output logic [31:0]        resp_data_o,
  output logic               busy_o
);

  localparam int SETS = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [31:0]         r_addr;
  logic [255:0]        r_line;
  logic                r_victim;
  logic                r_cancel;
  logic [SETS-1:0]     r_lru;

  logic [INDEX_W-1:0]  w_index;
  logic [INDEX_W-1:0]  w_miss_index;
  logic [TAG_W-1:0]    w_tag;
  logic [31:0]         w_words [8];

  assign w_index      = r_addr[INDEX_W+4:5];
  assign w_tag        = r_addr[31:INDEX_W+5];
  assign w_miss_index = miss_addr_i[INDEX_W+4:5];

  // Split the line buffer into its eight instruction words.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_word
      assign w_words[gi] = r_line[32*gi +: 32];
    end
  endgenerate

  // Write port and response data always reflect the latched miss; the
  // write enable and valid qualify them.
  assign icache_axi_addr_o = {r_addr[31:5], 5'b0};
  assign wr_index_o        = w_index;
  assign wr_tag_o          = w_tag;
  assign wr_line_o         = r_line;
  assign resp_data_o       = w_words[r_addr[4:2]];
  assign busy_o            = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Miss address, victim way, line buffer and cancel flag.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_addr   <= '0;
      r_victim <= 1'b0;
      r_line   <= '0;
      r_cancel <= 1'b0;
    end else begin
      if (r_state == S_IDLE && miss_i) begin
        r_addr   <= miss_addr_i;
        r_victim <= r_lru[w_miss_index];
      end
      if (r_state == S_WAIT && icache_axi_rend_i) begin
        r_line <= icache_axi_data_i;
      end
      // The burst always completes; a flush only drops the word return.
      if (w_state_next == S_IDLE) begin
        r_cancel <= 1'b0;
      end else if (flush_i && (r_state == S_REQ || r_state == S_WAIT ||
                               r_state == S_FILL)) begin
        r_cancel <= 1'b1;
      end
    end
  end

  // Per-set LRU bits (value = next victim); a fill overrides a same-cycle hit.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_lru <= '0;
    end else begin
      if (hit_i) begin
        r_lru[hit_index_i] <= ~hit_way_i;
      end
      if (r_state == S_FILL) begin
        r_lru[w_index] <= ~r_victim;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_next     = r_state;
    icache_axi_req_o = 1'b0;
    way_we_o         = 2'b00;
    resp_valid_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (miss_i) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        icache_axi_req_o = 1'b1;
        w_state_next     = S_WAIT;
      end
      S_WAIT: begin
        if (icache_axi_rend_i) begin
          w_state_next = S_FILL;
        end
      end
      S_FILL: begin
        way_we_o = r_victim ? 2'b10 : 2'b01;
`ifdef ICACHE_REFILL_BYPASS_EN
        resp_valid_o = ~(r_cancel | flush_i);
        w_state_next = S_IDLE;
`else
        w_state_next = S_DONE;
`endif
      end
      S_DONE: begin
        resp_valid_o = ~r_cancel;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_refill.sv
// Directed self-checking bench for icache_refill. Honours
// ICACHE_REFILL_BYPASS_EN for the expected response timing.
module tb_icache_refill;

  logic         aclk = 1'b0;
  logic         areset;
  logic         miss_i;
  logic [31:0]  miss_addr_i;
  logic         hit_i;
  logic         hit_way_i;
  logic [6:0]   hit_index_i;
  logic         flush_i;
  logic         icache_axi_req_o;
  logic [31:0]  icache_axi_addr_o;
  logic         icache_axi_rend_i;
  logic [255:0] icache_axi_data_i;
  logic [1:0]   way_we_o;
  logic [6:0]   wr_index_o;
  logic [19:0]  wr_tag_o;
  logic [255:0] wr_line_o;
  logic         resp_valid_o;
  logic [31:0]  resp_data_o;
  logic         busy_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  icache_refill dut (
    .aclk              (aclk),
    .areset            (areset),
    .miss_i            (miss_i),
    .miss_addr_i       (miss_addr_i),
    .hit_i             (hit_i),
    .hit_way_i         (hit_way_i),
    .hit_index_i       (hit_index_i),
    .flush_i           (flush_i),
    .icache_axi_req_o  (icache_axi_req_o),
    .icache_axi_addr_o (icache_axi_addr_o),
    .icache_axi_rend_i (icache_axi_rend_i),
    .icache_axi_data_i (icache_axi_data_i),
    .way_we_o          (way_we_o),
    .wr_index_o        (wr_index_o),
    .wr_tag_o          (wr_tag_o),
    .wr_line_o         (wr_line_o),
    .resp_valid_o      (resp_valid_o),
    .resp_data_o       (resp_data_o),
    .busy_o            (busy_o)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete refill. The request is at cycle 1 and rend at cycle
  // rend_cyc; optional flush pulse at cycle 3 (WAIT) and hit of way 0,
  // index 0 in the FILL cycle.
  task automatic refill(input logic [31:0] addr, input int rend_cyc,
                        input logic [1:0] exp_we, input logic [31:0] base,
                        input logic do_flush, input logic do_hit);
    logic [255:0] line;
    logic [31:0]  exp_word;
    for (int j = 0; j < 8; j++) line[32*j +: 32] = base + j;
    exp_word = base + {29'd0, addr[4:2]};
    $display("refill addr=%08h rend@%0d way_we=%b flush=%0d hit=%0d",
             addr, rend_cyc, exp_we, do_flush, do_hit);
    check("idle_busy", busy_o, 0);
    miss_i      = 1'b1;
    miss_addr_i = addr;
    tick();
    miss_i = 1'b0;
    check("req_pulse", icache_axi_req_o, 1);
    check("req_addr", icache_axi_addr_o, {addr[31:5], 5'b0});
    check("req_busy", busy_o, 1);
    tick();
    for (int c = 2; c <= rend_cyc; c++) begin
      check("wait_no_req", icache_axi_req_o, 0);
      check("wait_addr", icache_axi_addr_o, {addr[31:5], 5'b0});
      check("wait_busy", busy_o, 1);
      flush_i = do_flush && (c == 3);
      if (c == rend_cyc) begin
        icache_axi_rend_i = 1'b1;
        icache_axi_data_i = line;
      end
      tick();
    end
    icache_axi_rend_i = 1'b0;
    icache_axi_data_i = '0;
    flush_i           = 1'b0;
    check("fill_we", way_we_o, exp_we);
    check("fill_index", wr_index_o, addr[11:5]);
    check("fill_tag", wr_tag_o, addr[31:12]);
    check("fill_line", wr_line_o, line);
    check("fill_addr", icache_axi_addr_o, {addr[31:5], 5'b0});
`ifdef ICACHE_REFILL_BYPASS_EN
    check("fill_resp_valid", resp_valid_o, !do_flush);
    if (!do_flush) check("fill_resp_data", resp_data_o, exp_word);
`else
    check("fill_resp_valid", resp_valid_o, 0);
`endif
    if (do_hit) begin
      hit_i       = 1'b1;
      hit_way_i   = 1'b0;
      hit_index_i = 7'd0;
    end
    tick();
    hit_i = 1'b0;
    check("post_we", way_we_o, 0);
`ifdef ICACHE_REFILL_BYPASS_EN
    check("post_resp_valid", resp_valid_o, 0);
    check("post_busy", busy_o, 0);
`else
    check("done_resp_valid", resp_valid_o, !do_flush);
    if (!do_flush) check("done_resp_data", resp_data_o, exp_word);
    check("done_busy", busy_o, 1);
    tick();
    check("end_busy", busy_o, 0);
    check("end_resp_valid", resp_valid_o, 0);
`endif
  endtask

  task automatic hit(input logic way, input logic [6:0] idx);
    $display("hit way=%0d index=%0h", way, idx);
    hit_i       = 1'b1;
    hit_way_i   = way;
    hit_index_i = idx;
    tick();
    hit_i = 1'b0;
  endtask

  initial begin
    areset            = 1'b1;
    miss_i            = 1'b0;
    miss_addr_i       = '0;
    hit_i             = 1'b0;
    hit_way_i         = 1'b0;
    hit_index_i       = '0;
    flush_i           = 1'b0;
    icache_axi_rend_i = 1'b0;
    icache_axi_data_i = '0;
    tick();
    tick();
    $display("reset values");
    check("rst_busy", busy_o, 0);
    check("rst_req", icache_axi_req_o, 0);
    check("rst_addr", icache_axi_addr_o, 0);
    check("rst_we", way_we_o, 0);
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_resp_data", resp_data_o, 0);
    check("rst_line", wr_line_o, 0);
    areset = 1'b0;
    tick();

    // Basic refill: rend 10 cycles after the request.
    refill(32'h1FC0_0014, 11, 2'b01, 32'h0, 1'b0, 1'b0);
    // Same set again: LRU now points at way 1.
    refill(32'h2FC0_0008, 6, 2'b10, 32'h100, 1'b0, 1'b0);
    // LRU[0] back to 0 after that fill; a hit on way 0 makes it 1.
    hit(1'b0, 7'd0);
    // Fill way 1 while a hit on way 0 lands on the same set.
    refill(32'h3FC0_0000, 5, 2'b10, 32'h200, 1'b0, 1'b1);
    // FILL update must have won: victim is way 0.
    refill(32'h4FC0_0004, 4, 2'b01, 32'h300, 1'b0, 1'b0);
    // Flush in WAIT: line still written, no response.
    refill(32'h5FC0_0010, 6, 2'b10, 32'h400, 1'b1, 1'b0);

    // Reset in WAIT followed by a stale rend.
    hit(1'b0, 7'd0);
    $display("reset during WAIT");
    miss_i      = 1'b1;
    miss_addr_i = 32'h6FC0_0000;
    tick();
    miss_i = 1'b0;
    tick();
    tick();
    check("rstw_busy_pre", busy_o, 1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("rstw_busy", busy_o, 0);
    check("rstw_we", way_we_o, 0);
    tick();
    tick();
    icache_axi_rend_i = 1'b1;
    icache_axi_data_i = {8{32'hDEAD_BEEF}};
    tick();
    icache_axi_rend_i = 1'b0;
    icache_axi_data_i = '0;
    for (int c = 0; c < 3; c++) begin
      check("stale_we", way_we_o, 0);
      check("stale_resp_valid", resp_valid_o, 0);
      check("stale_busy", busy_o, 0);
      tick();
    end
    // LRU cleared by reset: victim for set 0 is way 0; shortest rend.
    refill(32'h7FC0_001C, 2, 2'b01, 32'h500, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
# icache_refill

Miss-handling stage of the instruction cache, sitting between the icache lookup logic and `icache_axi`. It accepts a miss from lookup, issues one line-aligned refill request to `icache_axi`, and captures the 8-word line returned on `icache_axi_rend`. It then writes the line and tag into the victim way chosen by a per-set LRU bit, and returns the missed word to the fetch stage.

## Interface
- `INDEX_W`, default 7: set-index width; 128 sets.
- `TAG_W`, default 20: tag width; `TAG_W + INDEX_W + 5 = 32`.
- `aclk`, in, 1: the single clock.
- `areset`, in, 1: synchronous, active-high reset.
- `miss_i`, in, 1: lookup miss, valid in IDLE only.
- `miss_addr_i`, in, 32: fetch address of the miss.
- `hit_i`, in, 1: lookup hit, used for the LRU update.
- `hit_way_i`, in, 1: way that hit.
- `hit_index_i`, in, INDEX_W: set index of the hit.
- `flush_i`, in, 1: pipeline flush; cancels the word return.
- `icache_axi_req_o`, out, 1: one-cycle refill request pulse to `icache_axi_req_i`.
- `icache_axi_addr_o`, out, 32: line-aligned address, `{tag, index, 5'b0}`.
- `icache_axi_rend_i`, in, 1: last beat of the burst handshaked.
- `icache_axi_data_i`, in, 256: full line, valid only in the `rend_i` cycle.
- `way_we_o`, out, 2: one-hot data/tag write enable.
- `wr_index_o`, out, INDEX_W: set index being written.
- `wr_tag_o`, out, TAG_W: tag being written; the valid bit is set with it.
- `wr_line_o`, out, 256: line data being written.
- `resp_valid_o`, out, 1: returned word is valid; one cycle.
- `resp_data_o`, out, 32: the missed instruction word.
- `busy_o`, out, 1: high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: on `miss_i`, latch `miss_addr_i` and the victim `lru[index]`, then go to REQ.
  - REQ: `icache_axi_req_o` = 1 for exactly one cycle, then go to WAIT.
  - WAIT: hold until `icache_axi_rend_i`. Latch `icache_axi_data_i` into the 256-bit line buffer, then go to FILL.
  - FILL: `way_we_o[victim]` = 1. Drive `wr_index_o`, `wr_tag_o` and `wr_line_o` from the latched values. Set `lru[index] = ~victim`, then go to DONE (or IDLE, see Configuration).
  - DONE: `resp_valid_o` = 1 unless the refill is cancelled, then go to IDLE.
- Word select: `resp_data_o = line[32*k+31 : 32*k]`, with `k = miss_addr[4:2]`.
- LRU array: `2^INDEX_W` bits.
  - Bit value = next victim way; all bits are 0 at reset.
  - A hit in any state sets `lru[hit_index_i] = ~hit_way_i`.
  - If a FILL-cycle write and a hit target the same index in the same cycle, the FILL update wins.
- `miss_i` outside IDLE is ignored; the lookup stage holds the miss until `busy_o` falls.
- `flush_i` in REQ, WAIT or FILL:
  - Sets a `cancel` flag.
  - The AXI burst is never aborted. The line is still written in FILL, and `resp_valid_o` is suppressed.
  - `cancel` clears on return to IDLE.
- `icache_axi_rend_i` outside WAIT is ignored.
- `icache_axi_addr_o` is held stable from REQ through FILL.

## Timing
- Reset values:
  - All outputs 0; state = IDLE.
  - Line buffer, latched address and `cancel` are 0.
  - LRU bits are 0.
- Reset mid-refill goes to IDLE in the next cycle. A stale `rend` arriving afterwards is ignored and no write occurs.
- Cycle sequence, with the miss seen in IDLE at cycle 0:
  - Request pulse at cycle 1.
  - If `rend` arrives at cycle N (N ≥ 2), the write happens at N+1 and the response at N+2.
- `busy_o` is high from cycle 1 until the cycle after the last state.
- Back-to-back misses: a new miss is accepted the first cycle state is IDLE again.

## Configuration
- Macro: `ICACHE_REFILL_BYPASS_EN`.
- Defined:
  - `resp_valid_o` is asserted in FILL, concurrent with the write, and the FSM goes FILL → IDLE. DONE is unused.
  - Response latency is `rend` + 1.
  - `flush_i` asserted in the FILL cycle itself still suppresses `resp_valid_o`.
- Undefined: the FILL → DONE path as described above; response latency is `rend` + 2.

## Test plan
- **Basic refill:** miss at `0x1FC0_0014`, `rend` 10 cycles after the request, line words `0x0..0x7` → request address `0x1FC0_0000`; `way_we_o` = `2'b01` at index `0x00`; `resp_data_o` = `0x5`; LRU[0] = 1.
- **Second miss to the same set:** miss at `0x2FC0_0008` → `way_we_o` = `2'b10`, tag `0x2FC00`, `resp_data_o` = word 2; LRU[0] = 0.
- **Hit/fill collision:** `hit_i` with way 0 at index 0, in the same cycle as the FILL write of way 1 at index 0 → LRU[0] = 0 (FILL wins).
- **Flush during WAIT:** `flush_i` pulse in WAIT → line still written; `resp_valid_o` never asserted; `busy_o` falls on schedule.
- **Reset in WAIT:** `areset` asserted in WAIT, then `rend` 3 cycles later → no `way_we_o`, no response; `busy_o` = 0.
- **Macro variants:** run the basic refill with and without `ICACHE_REFILL_BYPASS_EN` → `resp_valid_o` at `rend` + 1 and `rend` + 2 respectively.
